serial_subtractor: RTL and testbench

//  Multi-cycle, parametrised successor to the single-bit half subtractor: computes
//  d = x - y - b_in over WIDTH bits, STEP bits per clock, LSB first, via a chained

---
 rtl/serial_subtractor_if.sv | 20 ++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result bus.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    modport master (output start, x, y, b_in, input busy, done, d, b, ovf);
    modport slave  (input start, x, y, b_in, output busy, done, d, b, ovf);
`else
    modport master (output start, x, y, b_in, input busy, done, d, b);
    modport slave  (input start, x, y, b_in, output busy, done, d, b);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes x - y - b_in, STEP bits per clock, LSB first, with a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (WIDTH < 2 || STEP < 1 || WIDTH % STEP != 0) begin : g_bad_cfg
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of STEP");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d, d_q, d_d, r_nxt;
    logic             bor_q, bor_d, b_q, b_d, bor_nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load, fin;

    assign load = (state_q == IDLE || state_q == DONE) && bus.start;
    assign fin  = state_q == RUN && cnt_q == CW'(N - 1);

    // Ripple the borrow through STEP full-subtractor slices; results enter at the MSB end.
    always_comb begin
        bor_nxt = bor_q;
        r_nxt   = r_q >> STEP;
        for (int i = 0; i < STEP; i++) begin
            r_nxt[WIDTH-STEP+i] = x_q[i] ^ y_q[i] ^ bor_nxt;
            bor_nxt = (~x_q[i] & y_q[i]) | (~(x_q[i] ^ y_q[i]) & bor_nxt);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_d     = b_q;
        if (load) begin
            state_d = RUN;
            x_d     = bus.x;
            y_d     = bus.y;
            bor_d   = bus.b_in;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            x_d     = x_q >> STEP;
            y_d     = y_q >> STEP;
            r_d     = r_nxt;
            bor_d   = bor_nxt;
            cnt_d   = cnt_q + CW'(1);
            state_d = fin ? DONE : RUN;
            d_d     = fin ? r_nxt : d_q;
            b_d     = fin ? bor_nxt : b_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_q     <= b_d;
        end
    end

    assign bus.busy = state_q == RUN;
    assign bus.done = state_q == DONE;
    assign bus.d    = d_q;
    assign bus.b    = b_q;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because the x/y registers shift away.
    logic xm_q, xm_d, ym_q, ym_d, ovf_q, ovf_d;

    always_comb begin
        xm_d  = load ? bus.x[WIDTH-1] : xm_q;
        ym_d  = load ? bus.y[WIDTH-1] : ym_q;
        ovf_d = fin ? (xm_q ^ ym_q) & (xm_q ^ r_nxt[WIDTH-1]) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xm_q  <= 1'b0;
            ym_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            xm_q  <= xm_d;
            ym_q  <= ym_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench driving a STEP=1 and a STEP=4 instance (WIDTH=8).
// Drivers push expected results; per-lane monitors pop and compare on every done pulse.
module tb_serial_subtractor;
    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst4 = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] last_d[2];
    logic       last_b[2];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) i1 ();
    serial_subtractor_if #(.WIDTH(8)) i4 ();

    serial_subtractor #(.WIDTH(8), .STEP(1)) u1 (.clk(clk), .rst(rst1), .bus(i1.slave));
    serial_subtractor #(.WIDTH(8), .STEP(4)) u4 (.clk(clk), .rst(rst4), .bus(i4.slave));

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    function automatic logic lbusy(int k); return k == 0 ? i1.busy : i4.busy; endfunction
    function automatic logic ldone(int k); return k == 0 ? i1.done : i4.done; endfunction
    function automatic logic [7:0] ld(int k); return k == 0 ? i1.d : i4.d; endfunction
    function automatic logic lb(int k); return k == 0 ? i1.b : i4.b; endfunction

    task automatic set_rst(int k, logic v);
        if (k == 0) rst1 = v; else rst4 = v;
    endtask

    task automatic drive(int k, logic s, logic [7:0] xx, logic [7:0] yy, logic bb);
        if (k == 0) begin
            i1.start = s; i1.x = xx; i1.y = yy; i1.b_in = bb;
        end else begin
            i4.start = s; i4.x = xx; i4.y = yy; i4.b_in = bb;
        end
    endtask

    // Reference: plain 9-bit unsigned and integer signed arithmetic.
    function automatic exp_t model(logic [7:0] xx, logic [7:0] yy, logic bb);
        logic [8:0] r;
        int         s;
        exp_t       e;
        r   = {1'b0, xx} - {1'b0, yy} - 9'(bb);
        s   = int'($signed(xx)) - int'($signed(yy)) - int'(bb);
        e.d = r[7:0];
        e.b = r[8];
        e.o = (s < -128) || (s > 127);
        return e;
    endfunction

    task automatic issue(int k, logic [7:0] xx, logic [7:0] yy, logic bb, bit push, output exp_t e);
        e = model(xx, yy, bb);
        if (push) begin
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        drive(k, 1'b1, xx, yy, bb);
        @(posedge clk); #1;
        drive(k, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic wait_done(int k, output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!ldone(k) && cyc < 40) begin
            if (lbusy(k)) begin
                bc++;
                chk("hold_d", k, 32'(ld(k)), 32'(last_d[k]));
                chk("hold_b", k, 32'(lb(k)), 32'(last_b[k]));
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!ldone(k)) chk("done_timeout", k, 0, 1);
    endtask

    task automatic finish_op(int k, exp_t e);
        last_d[k] = e.d;
        last_b[k] = e.b;
    endtask

    task automatic op(int k, int n, logic [7:0] xx, logic [7:0] yy, logic bb);
        exp_t e;
        int   cyc, bc;
        issue(k, xx, yy, bb, 1'b1, e);
        wait_done(k, cyc, bc);
        chk("latency", k, 32'(cyc), 32'(n));
        chk("busy_cycles", k, 32'(bc), 32'(n));
        finish_op(k, e);
        @(posedge clk); #1;
    endtask

    task automatic lane(int k, int n);
        logic [7:0] dx[6] = '{8'h05, 8'h03, 8'h00, 8'hA5, 8'h80, 8'h7F};
        logic [7:0] dy[6] = '{8'h03, 8'h05, 8'h00, 8'h5A, 8'h01, 8'hFF};
        logic       db[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e;
        int   cyc, bc;
        last_d[k] = 8'h00;
        last_b[k] = 1'b0;
        drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
        set_rst(k, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        set_rst(k, 1'b0);
        chk("rst_busy", k, 32'(lbusy(k)), 0);
        chk("rst_done", k, 32'(ldone(k)), 0);
        chk("rst_d", k, 32'(ld(k)), 0);
        chk("rst_b", k, 32'(lb(k)), 0);
        for (int i = 0; i < 6; i++) op(k, n, dx[i], dy[i], db[i]);
        // start pulsed during RUN with different operands must be ignored
        issue(k, 8'h3C, 8'h11, 1'b0, 1'b1, e);
        drive(k, 1'b1, 8'h01, 8'hFE, 1'b1);
        @(posedge clk); #1;
        drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_done(k, cyc, bc);
        chk("midrun_latency", k, 32'(cyc), 32'(n - 1));
        finish_op(k, e);
        repeat (n + 2) @(posedge clk);
        #1;
        // back-to-back: start presented in the DONE cycle
        issue(k, 8'h10, 8'h20, 1'b1, 1'b1, e);
        wait_done(k, cyc, bc);
        finish_op(k, e);
        issue(k, 8'hC8, 8'h37, 1'b0, 1'b1, e);
        chk("b2b_busy", k, 32'(lbusy(k)), 1);
        wait_done(k, cyc, bc);
        chk("b2b_latency", k, 32'(cyc), 32'(n));
        finish_op(k, e);
        @(posedge clk); #1;
        // reset in the middle of RUN aborts the op
        issue(k, 8'hEE, 8'h12, 1'b0, 1'b0, e);
        repeat (n > 4 ? 3 : n - 1) @(posedge clk);
        #1;
        set_rst(k, 1'b1);
        @(posedge clk); #1;
        set_rst(k, 1'b0);
        chk("abort_busy", k, 32'(lbusy(k)), 0);
        chk("abort_done", k, 32'(ldone(k)), 0);
        chk("abort_d", k, 32'(ld(k)), 0);
        chk("abort_b", k, 32'(lb(k)), 0);
        last_d[k] = 8'h00;
        last_b[k] = 1'b0;
        repeat (n + 3) @(posedge clk);
        #1;
        op(k, n, 8'h05, 8'h03, 1'b0);
        repeat (60) op(k, n, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic check_pop(int k);
        exp_t e;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done lane%0d: got done=1 expected no completion", k);
        end else begin
            e = k == 0 ? q0.pop_front() : q1.pop_front();
            chk("d", k, 32'(ld(k)), 32'(e.d));
            chk("b", k, 32'(lb(k)), 32'(e.b));
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", k, 32'(k == 0 ? i1.ovf : i4.ovf), 32'(e.o));
`endif
            chk("done_busy_excl", k, 32'(lbusy(k)), 0);
        end
    endtask

    always @(negedge clk) if (i1.done === 1'b1) check_pop(0);
    always @(negedge clk) if (i4.done === 1'b1) check_pop(1);

    initial begin
        fork
            lane(0, 8);
            lane(1, 2);
        join
        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", 0, 32'(q0.size()), 0);
        chk("q1_drained", 1, 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "timeout");
    end
endmodule
